cdc_handshake_tx: RTL and testbench

Source-side endpoint of a 4-phase req/ack bus synchronizer. It accepts multi-bit words in its own clock domain, holds each word stable on `xfer_data`, and walks `xfer_req` through the full 4-phase handshake against an `xfer_ack` that arrives asynchronously from the destination domain. It sits in the source domain, opposite the destination-side capture logic. It is the only sanctioned way to move a multi-bit value across a clock boundary in this design.

---
 rtl/cdc_hs_pkg.sv | 13 +
 rtl/ack_sync.sv | 30 +++
 rtl/cdc_handshake_tx.sv | 118 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types for the source-side 4-phase req/ack synchronizer.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_REL
    } hs_state_t;

    localparam int HS_SYNC_MIN = 2;
    localparam int HS_SYNC_MAX = 4;

endpackage

// File: rtl/ack_sync.sv
// Single-bit multi-flop synchronizer with synchronous reset.
import cdc_hs_pkg::*;

module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    // Out-of-range depths are clamped to the legal 2..4 window.
    localparam int N = (SYNC_STAGES < HS_SYNC_MIN) ? HS_SYNC_MIN :
                       (SYNC_STAGES > HS_SYNC_MAX) ? HS_SYNC_MAX :
                       SYNC_STAGES;

    logic [N-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[N-2:0], d_i};
        end
    end

    assign q_o = chain_q[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side 4-phase handshake endpoint: FSM, pending buffer,
// held data register and completed-transfer counter.
import cdc_hs_pkg::*;

module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              src_clk,
    input  logic              src_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_count
);

    hs_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_s;
    logic              accept;
    logic              direct;
    logic              drain;

    ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(src_clk),
        .rst_i(src_rst),
        .d_i  (xfer_ack),
        .q_o  (ack_s)
    );

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state_q      <= HS_IDLE;
            req_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            data_q       <= data_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HS_IDLE: begin
                if (!ack_s && (pend_valid_q || accept)) begin
                    state_d = HS_REQ;
                end
            end
            HS_REQ: begin
                if (ack_s) begin
                    state_d = HS_REL;
                end
            end
            HS_REL: begin
                if (!ack_s) begin
                    state_d = pend_valid_q ? HS_REQ : HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    // Data may only move while both req and ack_s are low.
    always_comb begin
        accept = in_valid && in_ready;
        direct = (state_q == HS_IDLE) && !ack_s
                 && !pend_valid_q && accept;
        drain  = pend_valid_q && !ack_s
                 && (state_q == HS_IDLE || state_q == HS_REL);

        pend_valid_d = (pend_valid_q && !drain) || (accept && !direct);
        pend_data_d  = (accept && !direct) ? in_data : pend_data_q;

        data_d = data_q;
        if (direct) begin
            data_d = in_data;
        end else if (drain) begin
            data_d = pend_data_q;
        end

        req_d  = (state_d == HS_REQ);
        done_d = (state_q == HS_REL) && !ack_s;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, done_d};
    end

    always_comb begin
        in_ready   = !pend_valid_q;
        busy       = (state_q != HS_IDLE) || pend_valid_q;
        xfer_req   = req_q;
        xfer_data  = data_q;
        done       = done_q;
        xfer_count = cnt_q;
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench: random-delay destination model, word queue, count checks.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, xfer_req, done, busy;
    logic [DW-1:0] xfer_data;
    logic [15:0]   xfer_count;
    logic          xfer_ack;
    logic          in_ready4, xfer_req4, done4, busy4;
    logic [DW-1:0] xfer_data4;
    logic [3:0]    xfer_count4;

    always #5 clk = ~clk;

    cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(S), .CNT_W(16)) dut (
        .src_clk(clk), .src_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack),
        .done(done), .busy(busy), .xfer_count(xfer_count)
    );

    cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(S), .CNT_W(4)) dut4 (
        .src_clk(clk), .src_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .xfer_req(xfer_req4), .xfer_data(xfer_data4), .xfer_ack(xfer_ack),
        .done(done4), .busy(busy4), .xfer_count(xfer_count4)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_total = 0;
    int            done_cnt = 0;
    int            rise_cnt = 0;
    int            dmin = 0;
    int            dmax = 0;
    bit            stale = 0;
    bit            ready_dropped = 0;

    // Destination model: follows req after a random number of cycles.
    logic ack_r;
    int   dly;
    always @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
            dly   <= dmin;
        end else if (ack_r != xfer_req) begin
            if (dly <= 0) begin
                ack_r <= xfer_req;
                dly   <= $urandom_range(dmax, dmin);
            end else begin
                dly <= dly - 1;
            end
        end
    end
    assign xfer_ack = stale ? 1'b1 : ack_r;

    // Reference view of the synchronized ack and of reset having hit.
    logic [S-1:0] acks_m;
    logic         rst_q;
    always @(posedge clk) begin
        rst_q  <= rst;
        acks_m <= rst ? '0 : {acks_m[S-2:0], xfer_ack};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/none expected event", name);
    endtask

    logic          prev_req = 1'b0;
    logic          prev_done = 1'b0;
    logic          prev_acks = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_q && (prev_req || prev_acks)) begin
            chk("data_stable", xfer_data, prev_data);
        end
        if (!rst_q && xfer_req && !prev_req) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_req");
            end else begin
                chk("xfer_word", xfer_data, exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_single", prev_done, 0);
        end
        if (!in_ready) ready_dropped = 1;
        prev_req  = xfer_req;
        prev_done = done;
        prev_acks = acks_m[S-1];
        prev_data = xfer_data;
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_total = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input int budget);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
        end else begin
            exp_q.push_back(d);
            exp_total++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || xfer_req || xfer_ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || xfer_req || xfer_ack) fail_now("idle_timeout");
        repeat (S + 2) @(negedge clk);
    endtask

    initial begin
        int d0;
        int r0;
        int n;
        dmin = 3;
        dmax = 3;
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", xfer_req, 0);
        chk("rst_data", xfer_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", xfer_count, 0);
        chk("rst_count4", xfer_count4, 0);

        d0 = done_cnt;
        send(8'hA5, 50);
        wait_idle(200);
        chk("single_data", xfer_data, 8'hA5);
        chk("single_done", done_cnt - d0, 1);
        chk("single_count", xfer_count, 1);
        chk("single_busy", busy, 0);

        dmin = 0;
        dmax = 2;
        ready_dropped = 0;
        d0 = done_cnt;
        send(8'h01, 50);
        send(8'h02, 50);
        send(8'h03, 50);
        wait_idle(300);
        chk("b2b_ready_drop", ready_dropped, 1);
        chk("b2b_done", done_cnt - d0, 3);
        chk("b2b_count", xfer_count, 4);
        chk("b2b_queue", exp_q.size(), 0);

        stale = 1;
        do_reset();
        repeat (S + 2) @(negedge clk);
        send(8'h3C, 20);
        for (int i = 0; i < 10; i++) begin
            chk("stale_hold", xfer_req, 0);
            @(negedge clk);
        end
        stale = 0;
        n = 0;
        while (!xfer_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stale_req_seen", xfer_req, 1);
        chk("stale_wait", (n >= S), 1);
        wait_idle(200);
        chk("stale_count", xfer_count, 1);
        chk("stale_queue", exp_q.size(), 0);

        dmin = 15;
        dmax = 15;
        send(8'h55, 50);
        n = 0;
        while (!xfer_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_req_up", xfer_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_total = 0;
        chk("mid_rst_req", xfer_req, 0);
        chk("mid_rst_data", xfer_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_count", xfer_count, 0);
        dmin = 1;
        dmax = 1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        send(8'h77, 50);
        wait_idle(200);
        chk("post_rst_data", xfer_data, 8'h77);
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_count", xfer_count, 1);

        dmin = 0;
        dmax = 1;
        for (int i = 0; i < 16; i++) begin
            send(DW'($urandom), 50);
        end
        wait_idle(300);
        chk("wrap_count16", xfer_count, 17);
        chk("wrap_count4", xfer_count4, 1);

        dmin = 0;
        dmax = 20;
        r0 = rise_cnt;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send(DW'($urandom), 400);
        end
        wait_idle(1000);
        chk("rand_rises", rise_cnt - r0, 200);
        chk("rand_queue", exp_q.size(), 0);
        chk("rand_count16", xfer_count, exp_total);
        chk("rand_count4", xfer_count4, 32'(exp_total % 16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
